// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- sequential unsigned restoring divider
//
// Computes quotient and remainder of two WIDTH-bit unsigned operands. It
// produces one quotient bit per clock from a single WIDTH+1-bit subtract stage,
// built as an adder with an inverted divisor and a carry-in of 1.
//
// Handshake: start is sampled only in IDLE. The accepted operands are captured
// on that edge. busy is high for the WIDTH iterations. done then pulses for
// one cycle with the results already valid.
//
// Optional feature macro: DIV_SEQ_ZERO_CHECK_EN
//   defined   : a zero divisor skips the iterations and completes one cycle
//               after capture with quotient = all ones, remainder = dividend,
//               div_by_zero = 1.
//   undefined : no check. A zero divisor runs the normal iterations, which
//               give the same quotient/remainder. div_by_zero is tied 0.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled only in IDLE
//   dividend     in   [WIDTH] numerator, captured on accepted start
//   divisor      in   [WIDTH] denominator, captured on accepted start
//   busy         out  high while iterating (RUN)
//   done         out  one-cycle completion pulse
//   quotient     out  [WIDTH] registered quotient, held until next completion
//   remainder    out  [WIDTH] registered remainder, held until next completion
//   div_by_zero  out  registered divide-by-zero flag, updated per completion
// -----------------------------------------------------------------------------
module div_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_q;          // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] d_q;          // captured divisor
  logic [WIDTH-1:0] r_q;          // partial remainder (its top bit is always 0, so it is not stored)
  logic [CW-1:0]    count_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  // One restoring step.
  logic [WIDTH:0]   r_shift_d;
  logic [WIDTH:0]   diff_d;
  logic             qbit_d;
  logic [WIDTH-1:0] r_next_d;
  logic [WIDTH-1:0] q_next_d;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    r_shift_d = {r_q, q_q[WIDTH-1]};
    diff_d    = r_shift_d + ~{1'b0, d_q} + {{WIDTH{1'b0}}, 1'b1};
    // A clear top bit means there was no borrow: R' >= D, so the subtraction is kept.
    qbit_d    = ~diff_d[WIDTH];
    // Either choice is below 2^WIDTH, so dropping the top bit loses nothing.
    r_next_d  = qbit_d ? diff_d[WIDTH-1:0] : r_shift_d[WIDTH-1:0];
    q_next_d  = {q_q[WIDTH-2:0], qbit_d};
  end

`ifdef DIV_SEQ_ZERO_CHECK_EN
  logic zero_q;       // captured divisor was zero
  logic dbz_q;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_SEQ_ZERO_CHECK_EN
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            q_q     <= dividend;
            d_q     <= divisor;
            r_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef DIV_SEQ_ZERO_CHECK_EN
            zero_q  <= (divisor == '0);
`endif
          end
        end

        RUN: begin
`ifdef DIV_SEQ_ZERO_CHECK_EN
          if (zero_q) begin
            // No iterations have run yet, so q_q still holds the dividend.
            quotient_q  <= '1;
            remainder_q <= q_q;
            dbz_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else
`endif
          begin
            q_q     <= q_next_d;
            r_q     <= r_next_d;
            count_q <= count_q + 1'b1;
            if (count_q == LAST_ITER) begin
              // Load the outputs from this step's next values, not from q_q/r_q.
              quotient_q  <= q_next_d;
              remainder_q <= r_next_d;
`ifdef DIV_SEQ_ZERO_CHECK_EN
              dbz_q       <= 1'b0;
`endif
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIV_SEQ_ZERO_CHECK_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq -- self-checking bench for div_seq (WIDTH = 4).
// Every issued operation pushes its expected result to a scoreboard queue.
// A monitor pops and compares the queue on each done pulse. The scenario tasks
// also check timing and reset behaviour inline.
// -----------------------------------------------------------------------------
module tb_div_seq;

  localparam int WIDTH = 4;
`ifdef DIV_SEQ_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int   vectors    = 0;
  int   miscompares = 0;
  exp_t sb_q[$];

  div_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = ZC;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard monitor: compare every completion against the queue head.
  always @(negedge clk) begin
    if (done) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got q=%0d r=%0d dz=%0b, expected no completion",
                 quotient, remainder, div_by_zero);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({busy, quotient, remainder, div_by_zero} !== {1'b0, e.q, e.r, e.dz}) begin
          miscompares++;
          $display("FAIL result %0d/%0d: got busy=%0b q=%0d r=%0d dz=%0b, expected busy=0 q=%0d r=%0d dz=%0b",
                   e.a, e.b, busy, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
        end
      end
    end
  end

  // Drive one start pulse. Returns at the negedge after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (push) sb_q.push_back(model(a, b));
    @(negedge clk);
    start    = 1'b0;
    dividend = WIDTH'($urandom);   // scramble: must not affect the captured operation
    divisor  = WIDTH'($urandom);
  endtask

  // Count negedges until done is seen, bounded.
  task automatic wait_done(input int max_cycles, output int lat);
    lat = 0;
    while (!done && lat < max_cycles) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles, expected a done pulse", max_cycles);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%0b done=%0b q=%0d r=%0d dz=%0b, expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    issue(4'd13, 4'd3, 1'b1);
    for (int i = 0; i <= WIDTH + 1; i++) begin
      logic [1:0] exp_bd;
      if (i > 0) @(negedge clk);
      exp_bd = (i < WIDTH) ? 2'b10 : (i == WIDTH) ? 2'b01 : 2'b00;
      vectors++;
      if ({busy, done} !== exp_bd) begin
        miscompares++;
        $display("FAIL basic_timing edge %0d: got busy,done=%b, expected %b", i, {busy, done}, exp_bd);
      end
    end
    vectors++;
    if ({quotient, remainder} !== {4'd4, 4'd1}) begin
      miscompares++;
      $display("FAIL basic_hold: got q=%0d r=%0d, expected q=4 r=1", quotient, remainder);
    end
  endtask

  task automatic test_vectors();
    logic [WIDTH-1:0] as [3] = '{4'd15, 4'd5, 4'd0};
    logic [WIDTH-1:0] bs [3] = '{4'd1,  4'd7, 4'd9};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(as[i], bs[i], 1'b1);
      wait_done(20, lat);
      vectors++;
      if (lat != WIDTH) begin
        miscompares++;
        $display("FAIL latency %0d/%0d: got %0d, expected %0d", as[i], bs[i], lat, WIDTH);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    int exp_lat;
    exp_lat = ZC ? 1 : WIDTH;
    issue(4'd6, 4'd0, 1'b1);
    wait_done(20, lat);
    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL div_zero_latency: got %0d, expected %0d", lat, exp_lat);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int lat;
    issue(4'd9, 4'd2, 1'b1);
    start = 1'b1; dividend = 4'd15; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wait_done(20, lat);
    vectors++;
    if (lat != WIDTH - 2) begin
      miscompares++;
      $display("FAIL ignore_start_latency: got %0d, expected %0d", lat, WIDTH - 2);
    end
    // Any queued second operation would raise done here with an empty scoreboard.
    repeat (8) @(negedge clk);
    vectors++;
    if ({busy, quotient, remainder} !== {1'b0, 4'd4, 4'd1}) begin
      miscompares++;
      $display("FAIL ignore_start_hold: got busy=%0b q=%0d r=%0d, expected busy=0 q=4 r=1",
               busy, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(4'd14, 4'd3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%0b done=%0b q=%0d r=%0d dz=%0b, expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_idle: got busy=%0b, expected 0", busy);
    end
    issue(4'd14, 4'd3, 1'b1);
    wait_done(20, lat);
    vectors++;
    if (lat != WIDTH) begin
      miscompares++;
      $display("FAIL reset_mid_latency: got %0d, expected %0d", lat, WIDTH);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(WIDTH'(a), WIDTH'(b), 1'b1);
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_accept %0d/%0d: got busy=%0b, expected 1", a, b, busy);
        end
        repeat (WIDTH) @(negedge clk);
      end
    end
    repeat (WIDTH + 2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
